pipe_regs: RTL and testbench

PIPE_REGS -- requirements
Module: pipe_regs

---
 rtl/pipe_regs.sv | 101 ++++++++++
 tb/tb_pipe_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regs.sv
// pipe_regs: elastic register pipeline of STAGES stages with valid/ready
// handshaking on both sides. Empty stages accept words even while later
// stages are stalled, so bubbles collapse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (clears valids, loads RESET_VAL)
//   in_valid   upstream offers in_data
//   in_ready   pipeline accepts a word this cycle (combinational)
//   in_data    upstream data word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts a word this cycle
//   out_data   data register of the last stage
//   flush      synchronous discard of all held words (data registers untouched)
//   occupancy  number of valid stages, 0..STAGES
module pipe_regs #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d    [STAGES];
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [WIDTH-1:0]  up_d [STAGES];

    // rdy[k] = !v[k] || rdy[k+1] unrolls to "not every stage from k to the
    // output is full, or the output drains"; computed with a running AND so
    // the rdy vector never depends on itself.
    always_comb begin
        logic        full_tail;
        int unsigned k;
        rdy       = '0;
        full_tail = 1'b1;
        k         = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            k         = STAGES - 1 - i;
            full_tail = full_tail & v[k];
            rdy[k]    = !full_tail || out_ready;
        end
    end

    // Upstream view of each stage: the input port for stage 0, the previous
    // stage otherwise.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                d[i] <= RESET_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (flush) begin
                    v[i] <= 1'b0;
                end else if (rdy[i]) begin
                    v[i] <= up_v[i];
                end
                // Data only moves with a real word, so bubbles never toggle it.
                if (!flush && rdy[i] && up_v[i]) begin
                    d[i] <= up_d[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: directed and randomized self-checking bench for pipe_regs
// (WIDTH=8, STAGES=3, RESET_VAL=8'h5A).
module tb_pipe_regs;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q [$];

    pipe_regs #(
        .WIDTH    (8),
        .STAGES   (3),
        .RESET_VAL(8'h5A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_rdy;
        logic do_in;
        logic do_out;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  8'h5A);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_in_ready",  in_ready,  1'b1);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Streaming: 0x11, 0x22, 0x33 back to back with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11; #1;
        check("str_in_ready0", in_ready, 1'b1);
        tick(); in_data = 8'h22; #1;
        check("str_in_ready1", in_ready, 1'b1);
        check("str_valid_lat1", out_valid, 1'b0);
        tick(); in_data = 8'h33; #1;
        check("str_in_ready2", in_ready, 1'b1);
        check("str_valid_lat2", out_valid, 1'b0);
        tick(); in_valid = 1'b0; #1;
        check("str_out0_valid", out_valid, 1'b1);
        check("str_out0_data",  out_data,  8'h11);
        check("str_in_ready3",  in_ready,  1'b1);
        tick(); #1;
        check("str_out1_valid", out_valid, 1'b1);
        check("str_out1_data",  out_data,  8'h22);
        tick(); #1;
        check("str_out2_valid", out_valid, 1'b1);
        check("str_out2_data",  out_data,  8'h33);
        tick(); #1;
        check("str_empty_valid", out_valid, 1'b0);
        check("str_empty_occ",   occupancy, 2'd0);

        // Backpressure fill with 0xA0..0xA4, then drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0; #1;
        check("bp_rdy_a0", in_ready, 1'b1);
        tick(); in_data = 8'hA1; #1;
        check("bp_rdy_a1", in_ready, 1'b1);
        tick(); in_data = 8'hA2; #1;
        check("bp_rdy_a2", in_ready, 1'b1);
        tick(); in_data = 8'hA3; #1;
        check("bp_full_rdy",   in_ready,  1'b0);
        check("bp_full_occ",   occupancy, 2'd3);
        check("bp_full_valid", out_valid, 1'b1);
        check("bp_full_data",  out_data,  8'hA0);
        tick(); #1;
        check("bp_stall_rdy",  in_ready,  1'b0);
        check("bp_stall_occ",  occupancy, 2'd3);
        check("bp_stall_data", out_data,  8'hA0);
        out_ready = 1'b1; #1;
        check("bp_release_rdy", in_ready, 1'b1);
        tick(); in_data = 8'hA4; #1;
        check("bp_drain_a1", out_data,  8'hA1);
        check("bp_shift_occ", occupancy, 2'd3);
        tick(); in_valid = 1'b0; #1;
        check("bp_drain_a2", out_data,  8'hA2);
        check("bp_shift_occ2", occupancy, 2'd3);
        tick(); #1;
        check("bp_drain_a3", out_data, 8'hA3);
        tick(); #1;
        check("bp_drain_a4", out_data,  8'hA4);
        check("bp_drain_v4", out_valid, 1'b1);
        tick(); #1;
        check("bp_drained", out_valid, 1'b0);

        // Bubble collapse: one word parked in the last stage, two more behind it
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99;
        tick(); in_valid = 1'b0;
        tick();
        tick(); #1;
        check("bub_park_occ",  occupancy, 2'd1);
        check("bub_park_data", out_data,  8'h99);
        in_valid = 1'b1; in_data = 8'h55; #1;
        check("bub_rdy0", in_ready, 1'b1);
        tick(); #1;
        check("bub_occ2", occupancy, 2'd2);
        check("bub_rdy1", in_ready,  1'b1);
        tick(); in_valid = 1'b0; #1;
        check("bub_occ3", occupancy, 2'd3);
        check("bub_rdy2", in_ready,  1'b0);
        check("bub_head", out_data,  8'h99);
        out_ready = 1'b1;
        tick(); #1;
        check("bub_out1", out_data, 8'h55);
        tick(); #1;
        check("bub_out2", out_data, 8'h55);
        tick(); #1;
        check("bub_empty", out_valid, 1'b0);

        // Flush with a simultaneous input and output transfer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
        tick(); in_data = 8'hC2;
        tick(); in_data = 8'hC3;
        tick();
        in_data = 8'h77; flush = 1'b1; out_ready = 1'b1; #1;
        check("fl_cycle_valid", out_valid, 1'b1);
        check("fl_cycle_data",  out_data,  8'hC1);
        check("fl_cycle_rdy",   in_ready,  1'b1);
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        check("fl_occ",        occupancy, 2'd0);
        check("fl_valid",      out_valid, 1'b0);
        check("fl_data_kept",  out_data,  8'hC1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("fl_no_77", out_valid, 1'b0);
        end

        // Asynchronous reset between edges with a full pipe
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
        tick(); in_data = 8'hD2;
        tick(); in_data = 8'hD3;
        tick(); in_valid = 1'b0; #1;
        check("ar_full_occ", occupancy, 2'd3);
        #2; reset = 1'b1; #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_data",  out_data,  8'h5A);
        check("ar_occ",   occupancy, 2'd0);
        check("ar_rdy",   in_ready,  1'b1);
        #2; reset = 1'b0;
        in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        tick(); #1;
        check("ar_post_valid", out_valid, 1'b1);
        check("ar_post_data",  out_data,  8'hE1);
        check("ar_post_occ",   occupancy, 2'd1);
        tick(); #1;
        check("ar_post_empty", occupancy, 2'd0);

        // Random traffic against a FIFO scoreboard
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            #1;
            exp_rdy = (q.size() < 3) || out_ready;
            check("rnd_in_ready",  in_ready,  exp_rdy);
            check("rnd_occupancy", occupancy, 64'(q.size()));
            do_in  = in_valid && exp_rdy;
            do_out = out_valid && out_ready;
            if (do_out && q.size() > 0) begin
                check("rnd_order", out_data, q[0]);
            end
            if (do_out && q.size() > 0) void'(q.pop_front());
            if (do_in) q.push_back(in_data);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid && q.size() > 0) begin
                check("rnd_drain_order", out_data, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        #1;
        check("rnd_final_occ", occupancy, 64'(q.size()));
        check("rnd_final_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
